// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS CPU.
// Steps each instruction through fetch, decode, execute, memory and write-back,
// and drives the datapath enables, mux selects and the 4-bit ALUOp for the ALU
// control decoder.
module multicycle_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               ExtOp,
    output logic               LuiOp,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [3:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [STATE_W-1:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef enum logic [STATE_W-1:0] {
        S_IF, S_ID, S_EXR, S_WBR, S_EXI, S_WBI, S_MA, S_MR,
        S_WBM, S_MW, S_BR, S_J, S_JAL, S_JR, S_JALR
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register with synchronous reset back to instruction fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; decode dispatches on OpCode/Funct
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                case (OpCode)
                    OP_LW, OP_SW: state_d = S_MA;
                    OP_RTYPE: begin
                        if (Funct == FN_JR) begin
                            state_d = S_JR;
                        end else if (Funct == FN_JALR) begin
                            state_d = S_JALR;
                        end else begin
                            state_d = S_EXR;
                        end
                    end
                    OP_BEQ: state_d = S_BR;
                    OP_J:   state_d = S_J;
                    OP_JAL: state_d = S_JAL;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI:
                        state_d = S_EXI;
                    default: state_d = S_IF;
                endcase
            end
            S_EXR: state_d = S_WBR;
            S_EXI: state_d = S_WBI;
            S_MA:  state_d = (OpCode == OP_SW) ? S_MW : S_MR;
            S_MR:  state_d = S_WBM;
            default: state_d = S_IF;
        endcase
    end

    // Moore outputs per state; reset forces everything to zero
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ExtOp       = 1'b0;
        LuiOp       = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 4'b0000;
        PCSource    = 2'b00;
        State       = S_IF;
        if (!reset) begin
            State = state_q;
            case (state_q)
                S_IF: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'b01;
                end
                S_ID: begin
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                end
                S_EXR: begin
                    ALUSrcA = ((Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA))
                              ? 2'b10 : 2'b01;
                    ALUOp   = 4'b0010;
                end
                S_WBR: begin
                    RegDst   = 2'b01;
                    RegWrite = 1'b1;
                end
                S_EXI: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ExtOp   = (OpCode != OP_ANDI);
                    case (OpCode)
                        OP_ADDIU: ALUOp = 4'b1000;
                        OP_ANDI:  ALUOp = 4'b0011;
                        OP_SLTI:  ALUOp = 4'b0100;
                        OP_SLTIU: ALUOp = 4'b1100;
                        OP_LUI:   LuiOp = 1'b1;
                        default:  ALUOp = 4'b0000;
                    endcase
                end
                S_WBI: RegWrite = 1'b1;
                S_MA: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ExtOp   = 1'b1;
                end
                S_MR: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_WBM: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                end
                S_MW: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_BR: begin
                    ALUSrcA     = 2'b01;
                    ALUOp       = 4'b0001;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_J: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_JAL: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
                S_JR: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                end
                S_JALR: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                    RegWrite = 1'b1;
                    RegDst   = 2'b01;
                    MemtoReg = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg;
    logic       ExtOp, LuiOp;
    logic [1:0] ALUSrcA, ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    // Expected state encodings (declaration order of the controller's states)
    localparam logic [3:0] S_IF = 4'd0,  S_ID = 4'd1,  S_EXR = 4'd2,  S_WBR = 4'd3;
    localparam logic [3:0] S_EXI = 4'd4, S_WBI = 4'd5, S_MA = 4'd6,   S_MR = 4'd7;
    localparam logic [3:0] S_WBM = 4'd8, S_MW = 4'd9,  S_BR = 4'd10,  S_J = 4'd11;
    localparam logic [3:0] S_JAL = 4'd12, S_JR = 4'd13, S_JALR = 4'd14;

    // Output bundle: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite RegWrite
    //                RegDst MemtoReg ExtOp LuiOp ALUSrcA ALUSrcB ALUOp PCSource
    logic [22:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                   RegDst, MemtoReg, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    localparam logic [22:0] E_ZERO   = '0;
    localparam logic [22:0] E_IF     = {7'b1001010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b00};
    localparam logic [22:0] E_ID     = {7'b0000000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 4'b0000, 2'b00};
    localparam logic [22:0] E_MA     = {7'b0000000, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 4'b0000, 2'b00};
    localparam logic [22:0] E_MR     = {7'b0011000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
    localparam logic [22:0] E_MW     = {7'b0010100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
    localparam logic [22:0] E_WBM    = {7'b0000001, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
    localparam logic [22:0] E_EXR_SH = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0010, 2'b00};
    localparam logic [22:0] E_EXR_RS = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0010, 2'b00};
    localparam logic [22:0] E_WBR    = {7'b0000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
    localparam logic [22:0] E_WBI    = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
    localparam logic [22:0] E_SLTIU  = {7'b0000000, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 4'b1100, 2'b00};
    localparam logic [22:0] E_ANDI   = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 4'b0011, 2'b00};
    localparam logic [22:0] E_LUI    = {7'b0000000, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10, 4'b0000, 2'b00};
    localparam logic [22:0] E_BR     = {7'b0100000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0001, 2'b01};
    localparam logic [22:0] E_J      = {7'b1000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b10};
    localparam logic [22:0] E_JAL    = {7'b1000001, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b10};
    localparam logic [22:0] E_JR     = {7'b1000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b11};
    localparam logic [22:0] E_JALR   = {7'b1000001, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b11};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [3:0]  st;
        logic [22:0] ex;
    } row_t;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ExtOp(ExtOp), .LuiOp(LuiOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .State(State)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; OpCode = 6'h00; Funct = 6'h00;
        step(); step();
        checks++;
        if (State !== S_IF) begin errors++; $display("FAIL reset_state got %0d want %0d", State, S_IF); end
        checks++;
        if (outs !== E_ZERO) begin errors++; $display("FAIL reset_outs got %h want %h", outs, E_ZERO); end
        reset = 1'b0; #1;
        checks++;
        if (outs !== E_IF) begin errors++; $display("FAIL reset_release_outs got %h want %h", outs, E_IF); end
    endtask

    // Starts in IF (current cycle); rows[0] is that IF cycle
    task automatic test_lw();
        row_t rows[$];
        rows = '{'{6'h23, 6'h00, S_IF, E_IF}, '{6'h23, 6'h00, S_ID, E_ID},
                 '{6'h23, 6'h00, S_MA, E_MA}, '{6'h23, 6'h00, S_MR, E_MR},
                 '{6'h23, 6'h00, S_WBM, E_WBM}, '{6'h23, 6'h00, S_IF, E_IF}};
        foreach (rows[i]) begin
            if (i > 0) step();
            OpCode = rows[i].op; Funct = rows[i].fn; #1;
            checks++;
            if (State !== rows[i].st) begin errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, State, rows[i].st); end
            checks++;
            if (outs !== rows[i].ex) begin errors++; $display("FAIL lw_outs[%0d] got %h want %h", i, outs, rows[i].ex); end
        end
    endtask

    task automatic test_r_type();
        row_t rows[$];
        rows = '{'{6'h00, 6'h02, S_IF, E_IF}, '{6'h00, 6'h02, S_ID, E_ID},
                 '{6'h00, 6'h02, S_EXR, E_EXR_SH}, '{6'h00, 6'h02, S_WBR, E_WBR},
                 '{6'h00, 6'h20, S_IF, E_IF}, '{6'h00, 6'h20, S_ID, E_ID},
                 '{6'h00, 6'h20, S_EXR, E_EXR_RS}, '{6'h00, 6'h20, S_WBR, E_WBR},
                 '{6'h00, 6'h20, S_IF, E_IF}};
        foreach (rows[i]) begin
            if (i > 0) step();
            OpCode = rows[i].op; Funct = rows[i].fn; #1;
            checks++;
            if (State !== rows[i].st) begin errors++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, State, rows[i].st); end
            checks++;
            if (outs !== rows[i].ex) begin errors++; $display("FAIL rtype_outs[%0d] got %h want %h", i, outs, rows[i].ex); end
        end
    endtask

    task automatic test_i_type();
        row_t rows[$];
        rows = '{'{6'h0b, 6'h00, S_IF, E_IF}, '{6'h0b, 6'h00, S_ID, E_ID},
                 '{6'h0b, 6'h00, S_EXI, E_SLTIU}, '{6'h0b, 6'h00, S_WBI, E_WBI},
                 '{6'h0c, 6'h00, S_IF, E_IF}, '{6'h0c, 6'h00, S_ID, E_ID},
                 '{6'h0c, 6'h00, S_EXI, E_ANDI}, '{6'h0c, 6'h00, S_WBI, E_WBI},
                 '{6'h0f, 6'h00, S_IF, E_IF}, '{6'h0f, 6'h00, S_ID, E_ID},
                 '{6'h0f, 6'h00, S_EXI, E_LUI}, '{6'h0f, 6'h00, S_WBI, E_WBI},
                 '{6'h0f, 6'h00, S_IF, E_IF}};
        foreach (rows[i]) begin
            if (i > 0) step();
            OpCode = rows[i].op; Funct = rows[i].fn; #1;
            checks++;
            if (State !== rows[i].st) begin errors++; $display("FAIL itype_state[%0d] got %0d want %0d", i, State, rows[i].st); end
            checks++;
            if (outs !== rows[i].ex) begin errors++; $display("FAIL itype_outs[%0d] got %h want %h", i, outs, rows[i].ex); end
        end
    endtask

    task automatic test_jumps();
        row_t rows[$];
        rows = '{'{6'h03, 6'h00, S_IF, E_IF}, '{6'h03, 6'h00, S_ID, E_ID}, '{6'h03, 6'h00, S_JAL, E_JAL},
                 '{6'h02, 6'h00, S_IF, E_IF}, '{6'h02, 6'h00, S_ID, E_ID}, '{6'h02, 6'h00, S_J, E_J},
                 '{6'h00, 6'h08, S_IF, E_IF}, '{6'h00, 6'h08, S_ID, E_ID}, '{6'h00, 6'h08, S_JR, E_JR},
                 '{6'h00, 6'h09, S_IF, E_IF}, '{6'h00, 6'h09, S_ID, E_ID}, '{6'h00, 6'h09, S_JALR, E_JALR},
                 '{6'h04, 6'h00, S_IF, E_IF}, '{6'h04, 6'h00, S_ID, E_ID}, '{6'h04, 6'h00, S_BR, E_BR},
                 '{6'h04, 6'h00, S_IF, E_IF}};
        foreach (rows[i]) begin
            if (i > 0) step();
            OpCode = rows[i].op; Funct = rows[i].fn; #1;
            checks++;
            if (State !== rows[i].st) begin errors++; $display("FAIL jump_state[%0d] got %0d want %0d", i, State, rows[i].st); end
            checks++;
            if (outs !== rows[i].ex) begin errors++; $display("FAIL jump_outs[%0d] got %h want %h", i, outs, rows[i].ex); end
        end
    endtask

    // Illegal opcodes go straight back to fetch after decode
    task automatic test_illegal();
        row_t rows[$];
        rows = '{'{6'h3f, 6'h00, S_IF, E_IF}, '{6'h3f, 6'h00, S_ID, E_ID}, '{6'h0d, 6'h00, S_IF, E_IF},
                 '{6'h0d, 6'h00, S_ID, E_ID}, '{6'h0d, 6'h00, S_IF, E_IF}};
        foreach (rows[i]) begin
            if (i > 0) step();
            OpCode = rows[i].op; Funct = rows[i].fn; #1;
            checks++;
            if (State !== rows[i].st) begin errors++; $display("FAIL illegal_state[%0d] got %0d want %0d", i, State, rows[i].st); end
            checks++;
            if (outs !== rows[i].ex) begin errors++; $display("FAIL illegal_outs[%0d] got %h want %h", i, outs, rows[i].ex); end
        end
    endtask

    // sw immediately followed by lw, sharing the IF cycle between them
    task automatic test_back_to_back();
        row_t rows[$];
        rows = '{'{6'h2b, 6'h00, S_IF, E_IF}, '{6'h2b, 6'h00, S_ID, E_ID}, '{6'h2b, 6'h00, S_MA, E_MA},
                 '{6'h2b, 6'h00, S_MW, E_MW}, '{6'h23, 6'h00, S_IF, E_IF}, '{6'h23, 6'h00, S_ID, E_ID},
                 '{6'h23, 6'h00, S_MA, E_MA}, '{6'h23, 6'h00, S_MR, E_MR}};
        foreach (rows[i]) begin
            if (i > 0) step();
            OpCode = rows[i].op; Funct = rows[i].fn; #1;
            checks++;
            if (State !== rows[i].st) begin errors++; $display("FAIL b2b_state[%0d] got %0d want %0d", i, State, rows[i].st); end
            checks++;
            if (outs !== rows[i].ex) begin errors++; $display("FAIL b2b_outs[%0d] got %h want %h", i, outs, rows[i].ex); end
        end
    endtask

    // Entered while sitting in MR of a lw; reset is held for two edges
    task automatic test_reset_mid_lw();
        reset = 1'b1; #1;
        checks++;
        if (outs !== E_ZERO) begin errors++; $display("FAIL midreset_outs_now got %h want %h", outs, E_ZERO); end
        step();
        checks++;
        if (State !== S_IF) begin errors++; $display("FAIL midreset_state1 got %0d want %0d", State, S_IF); end
        checks++;
        if (outs !== E_ZERO) begin errors++; $display("FAIL midreset_outs1 got %h want %h", outs, E_ZERO); end
        step();
        checks++;
        if (outs !== E_ZERO) begin errors++; $display("FAIL midreset_outs2 got %h want %h", outs, E_ZERO); end
        reset = 1'b0; #1;
        checks++;
        if (State !== S_IF) begin errors++; $display("FAIL midreset_release_state got %0d want %0d", State, S_IF); end
        checks++;
        if (outs !== E_IF) begin errors++; $display("FAIL midreset_release_outs got %h want %h", outs, E_IF); end
        step();
        checks++;
        if (State !== S_ID) begin errors++; $display("FAIL midreset_next_state got %0d want %0d", State, S_ID); end
        checks++;
        if (outs !== E_ID) begin errors++; $display("FAIL midreset_next_outs got %h want %h", outs, E_ID); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_r_type();
        test_i_type();
        test_jumps();
        test_illegal();
        test_back_to_back();
        test_reset_mid_lw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
